// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: sequences fetch/decode/exec/mem/writeback,
// drives datapath enables, counts retired instructions, traps on bad opcodes/timeouts.
module legv8_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic [RET_W-1:0] retired,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state
);

  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0, C_R = 3'd1, C_LD = 3'd2, C_ST = 3'd3, C_CBZ = 3'd4, C_B = 3'd5
  } cls_t;

  state_t           r_state;
  cls_t             r_cls;
  logic [TW-1:0]    r_tcnt;
  logic [RET_W-1:0] r_retired;
  logic             r_illegal;
  logic             r_bus_err;

  cls_t   w_dec_cls;
  state_t w_done_st;

  always_comb begin
    w_dec_cls = C_NONE;
    if (opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
        opcode == 11'b10001010000 || opcode == 11'b10101010000)
      w_dec_cls = C_R;
    else if (opcode == 11'b11111000010)
      w_dec_cls = C_LD;
    else if (opcode == 11'b11111000000)
      w_dec_cls = C_ST;
    else if (opcode[10:3] == 8'b10110100)
      w_dec_cls = C_CBZ;
    else if (opcode[10:5] == 6'b000101)
      w_dec_cls = C_B;
  end

  // Where an instruction goes once it has retired: run=0 parks the core.
  assign w_done_st = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cls     <= C_NONE;
      r_tcnt    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (pc_write) r_retired <= r_retired + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FETCH;
            r_tcnt  <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_state <= S_DECODE;
          end else if (r_tcnt == TMAX) begin
            r_state   <= S_TRAP;
            r_bus_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_DECODE: begin
          r_cls <= w_dec_cls;
          if (w_dec_cls == C_NONE) begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_tcnt <= '0;
          case (r_cls)
            C_R:         r_state <= S_WB;
            C_LD, C_ST:  r_state <= S_MEM;
            C_CBZ, C_B:  r_state <= w_done_st;
            default:     r_state <= S_TRAP;
          endcase
        end
        S_MEM: begin
          // An ack on the last permitted cycle takes priority over the timeout.
          if (dmem_ack) begin
            r_tcnt  <= '0;
            r_state <= (r_cls == C_LD) ? S_WB : w_done_st;
          end else if (r_tcnt == TMAX) begin
            r_state   <= S_TRAP;
            r_bus_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_WB: begin
          r_tcnt  <= '0;
          r_state <= w_done_st;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  // Moore decode from registered state/class; ir_write and CBZ pc_src follow their inputs.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
      end
      S_EXEC: begin
        case (r_cls)
          C_R: alu_op = 2'b10;
          C_LD: alu_src = 1'b1;
          C_ST: begin
            alu_src = 1'b1;
            reg2loc = 1'b1;
          end
          C_CBZ: begin
            reg2loc  = 1'b1;
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_src   = zero;
          end
          C_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_rd  = (r_cls == C_LD);
        dmem_wr  = (r_cls == C_ST);
        pc_write = (r_cls == C_ST) && dmem_ack;
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (r_cls == C_LD);
      end
      default: ;
    endcase
  end

  assign retired = r_retired;
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign state   = r_state;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl: per-cycle expected outputs are queued by
// the driver and checked by an independent monitor on the falling edge.
module tb_legv8_multicycle_ctrl;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_LDU = 11'b11111000010;
  localparam logic [10:0] OP_STU = 11'b11111000000;
  localparam logic [10:0] OP_CBZ = 11'b10110100101;
  localparam logic [10:0] OP_B   = 11'b00010100000;
  localparam logic [10:0] OP_BAD = 11'b11111111111;

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] sb;
    logic [3:0]  ret;
    logic        ill;
    logic        be;
  } exp_t;

  logic        clk, rst_n, run, zero, imem_ack, dmem_ack;
  logic [10:0] opcode;
  logic        imem_req, ir_write, dmem_rd, dmem_wr, pc_write, pc_src;
  logic        reg_write, reg2loc, alu_src, mem_to_reg, illegal, bus_err;
  logic [1:0]  alu_op;
  logic [3:0]  retired;
  logic [2:0]  state;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(4), .RET_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .retired(retired), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bits: imem_req ir_write dmem_rd dmem_wr pc_write pc_src reg_write reg2loc alu_src alu_op[1:0] mem_to_reg
  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      exp_t e;
      logic [11:0] sb;
      e  = q.pop_front();
      sb = {imem_req, ir_write, dmem_rd, dmem_wr, pc_write, pc_src,
            reg_write, reg2loc, alu_src, alu_op, mem_to_reg};
      total++;
      if (state !== e.st || sb !== e.sb || retired !== e.ret ||
          illegal !== e.ill || bus_err !== e.be) begin
        bad++;
        $display("FAIL cycle%0d: got st=%0d sb=%h ret=%0d ill=%b be=%b want st=%0d sb=%h ret=%0d ill=%b be=%b",
                 cyc, state, sb, retired, illegal, bus_err, e.st, e.sb, e.ret, e.ill, e.be);
      end
    end
  end

  task automatic step(input logic rv, rn, input logic [10:0] opc,
                      input logic z, ia, da, input logic [2:0] es,
                      input logic [11:0] ss, input logic [3:0] er,
                      input logic ei, eb);
    @(posedge clk);
    #1;
    rst_n = rv; run = rn; opcode = opc; zero = z; imem_ack = ia; dmem_ack = da;
    q.push_back('{st: es, sb: ss, ret: er, ill: ei, be: eb});
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    // reset state, then ADD
    step(0, 1, OP_ADD, 0, 1, 1, 0, 12'h000, 0, 0, 0);
    step(1, 1, OP_ADD, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    step(1, 1, OP_ADD, 0, 1, 0, 1, 12'hC00, 0, 0, 0);
    step(1, 1, OP_ADD, 0, 0, 0, 2, 12'h000, 0, 0, 0);
    step(1, 1, OP_ADD, 0, 0, 0, 3, 12'h004, 0, 0, 0);
    step(1, 1, OP_ADD, 0, 0, 0, 5, 12'h0A0, 0, 0, 0);
    // LDUR with dmem_ack on the 4th MEM cycle (last permitted)
    step(1, 1, OP_LDU, 0, 1, 0, 1, 12'hC00, 1, 0, 0);
    step(1, 1, OP_LDU, 0, 0, 0, 2, 12'h000, 1, 0, 0);
    step(1, 1, OP_LDU, 0, 0, 0, 3, 12'h008, 1, 0, 0);
    step(1, 1, OP_LDU, 0, 0, 0, 4, 12'h200, 1, 0, 0);
    step(1, 1, OP_LDU, 0, 0, 0, 4, 12'h200, 1, 0, 0);
    step(1, 1, OP_LDU, 0, 0, 0, 4, 12'h200, 1, 0, 0);
    step(1, 1, OP_LDU, 0, 0, 1, 4, 12'h200, 1, 0, 0);
    step(1, 1, OP_LDU, 0, 0, 0, 5, 12'h0A1, 1, 0, 0);
    // CBZ taken then not taken; run drops mid-instruction
    step(1, 1, OP_CBZ, 1, 1, 0, 1, 12'hC00, 2, 0, 0);
    step(1, 1, OP_CBZ, 1, 0, 0, 2, 12'h000, 2, 0, 0);
    step(1, 1, OP_CBZ, 1, 0, 0, 3, 12'h0D2, 2, 0, 0);
    step(1, 1, OP_CBZ, 0, 1, 0, 1, 12'hC00, 3, 0, 0);
    step(1, 0, OP_CBZ, 0, 0, 0, 2, 12'h000, 3, 0, 0);
    step(1, 0, OP_CBZ, 0, 0, 0, 3, 12'h092, 3, 0, 0);
    // IDLE ignores acks
    step(1, 0, OP_STU, 0, 1, 1, 0, 12'h000, 4, 0, 0);
    step(1, 1, OP_STU, 0, 0, 0, 0, 12'h000, 4, 0, 0);
    // STUR, reset asserted mid-MEM
    step(1, 1, OP_STU, 0, 1, 0, 1, 12'hC00, 4, 0, 0);
    step(1, 1, OP_STU, 0, 0, 0, 2, 12'h000, 4, 0, 0);
    step(1, 1, OP_STU, 0, 0, 0, 3, 12'h018, 4, 0, 0);
    step(1, 1, OP_STU, 0, 0, 0, 4, 12'h100, 4, 0, 0);
    step(0, 1, OP_STU, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    step(0, 1, OP_STU, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    // illegal opcode traps; TRAP is inert for 20 cycles
    step(1, 1, OP_BAD, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    step(1, 1, OP_BAD, 0, 1, 0, 1, 12'hC00, 0, 0, 0);
    step(1, 1, OP_BAD, 0, 0, 0, 2, 12'h000, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step(1, 1, OP_ADD, 1, 1, 1, 6, 12'h000, 0, 1, 0);
    step(0, 1, OP_ADD, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    // fetch timeout: imem_req for exactly 4 cycles, then bus error
    step(1, 1, OP_ADD, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 1, OP_ADD, 0, 0, 0, 1, 12'h800, 0, 0, 0);
    step(1, 1, OP_ADD, 0, 1, 1, 6, 12'h000, 0, 0, 1);
    step(1, 1, OP_ADD, 0, 1, 1, 6, 12'h000, 0, 0, 1);
    step(0, 1, OP_ADD, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    // ack on the 4th fetch cycle wins over the timeout
    step(1, 1, OP_ADD, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 1, OP_ADD, 0, 0, 0, 1, 12'h800, 0, 0, 0);
    step(1, 1, OP_ADD, 0, 1, 0, 1, 12'hC00, 0, 0, 0);
    step(1, 1, OP_ADD, 0, 0, 0, 2, 12'h000, 0, 0, 0);
    step(0, 1, OP_ADD, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    // 16 branches wrap the 4-bit retired counter back to 0
    step(1, 1, OP_B, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, OP_B, 0, 1, 0, 1, 12'hC00, 4'(i), 0, 0);
      step(1, 1, OP_B, 0, 0, 0, 2, 12'h000, 4'(i), 0, 0);
      step(1, (i == 15) ? 1'b0 : 1'b1, OP_B, 0, 0, 0, 3, 12'h0C0, 4'(i), 0, 0);
    end
    step(1, 0, OP_B, 0, 0, 0, 0, 12'h000, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expected records left unchecked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
